// File: rtl/wta_spike_decoder_if.sv
// -----------------------------------------------------------------------------
// wta_spike_decoder_if
// Result channel of the WTA spike decoder: one record per gamma cycle,
// transferred on out_valid && out_ready.
//   out_valid  : result valid (decoder -> consumer)
//   out_ready  : consumer accepts result (consumer -> decoder)
//   out_hit    : at least one spike edge in the reported gamma cycle
//   out_index  : winning line index
//   out_time   : gamma counter value at the winning edge
//   out_count  : number of distinct lines with an edge in the cycle
// Modports: master = decoder side, slave = consumer side.
// -----------------------------------------------------------------------------
interface wta_spike_decoder_if #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_INPUTS        = 128
);
    localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int IW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(NUM_INPUTS + 1);

    logic          out_valid;
    logic          out_ready;
    logic          out_hit;
    logic [IW-1:0] out_index;
    logic [TW-1:0] out_time;
    logic [CW-1:0] out_count;

    modport master (
        output out_valid, out_hit, out_index, out_time, out_count,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_hit, out_index, out_time, out_count,
        output out_ready
    );
endinterface

// File: rtl/wta_spike_decoder.sv
// -----------------------------------------------------------------------------
// wta_spike_decoder
// Consumes the WTA stage spike bus. Per gamma cycle it time-stamps the earliest
// rising spike edge and reports winner index, spike time and the number of
// distinct lines that fired, as one valid/ready record per gamma cycle.
// Ports:
//   aclk          clock
//   rst_n         asynchronous active-low reset
//   input_spikes  spike bus (level pulses), NUM_INPUTS wide
//   gamma_start   high while the gamma counter is 0
//   overflow      sticky, set when a result had to be dropped
//   pulse_err     (PULSE_CHECK_EN only) sticky, a line stayed high for more
//                 than PULSE_WIDTH consecutive cycles
//   res           result channel (wta_spike_decoder_if.master)
// Optional feature macro: PULSE_CHECK_EN
// -----------------------------------------------------------------------------
module wta_spike_decoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 128
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] input_spikes,
    output logic                  gamma_start,
    output logic                  overflow,
`ifdef PULSE_CHECK_EN
    output logic                  pulse_err,
`endif
    wta_spike_decoder_if.master   res
);
    localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int IW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(NUM_INPUTS + 1);

    if (GAMMA_CYCLE_WIDTH < 2 || PULSE_WIDTH < 1) begin : g_param_check
        $error("wta_spike_decoder: GAMMA_CYCLE_WIDTH must be >= 2 and PULSE_WIDTH >= 1");
    end

    // Gamma window state
    logic [TW-1:0]         r_t;
    logic [NUM_INPUTS-1:0] r_prev;
    logic [NUM_INPUTS-1:0] r_seen;
    logic                  r_hit;
    logic [IW-1:0]         r_widx;
    logic [TW-1:0]         r_wtime;

    // Output register
    logic                  r_valid;
    logic                  r_o_hit;
    logic [IW-1:0]         r_o_idx;
    logic [TW-1:0]         r_o_time;
    logic [CW-1:0]         r_o_count;
    logic                  r_overflow;

    logic [NUM_INPUTS-1:0] w_edge;
    logic [NUM_INPUTS-1:0] w_seen_next;
    logic                  w_any_edge;
    logic                  w_last;
    logic [IW-1:0]         w_first_idx;
    logic [CW-1:0]         w_count;
    logic                  w_res_hit;
    logic [IW-1:0]         w_res_idx;
    logic [TW-1:0]         w_res_time;

    assign w_edge      = input_spikes & ~r_prev;
    assign w_seen_next = r_seen | w_edge;
    assign w_any_edge  = |w_edge;
    assign w_last      = (r_t == TW'(GAMMA_CYCLE_WIDTH - 1));
    assign gamma_start = (r_t == '0);

    // Lowest set edge wins; scan from the top so the last assignment is the lowest index.
    always_comb begin
        w_first_idx = '0;
        for (int unsigned i = NUM_INPUTS; i > 0; i--) begin
            if (w_edge[i-1]) w_first_idx = IW'(i - 1);
        end
    end

    always_comb begin
        w_count = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            w_count = w_count + CW'(w_seen_next[i]);
        end
    end

    // Result as seen at the last tick: an edge in that tick can still become the winner.
    assign w_res_hit  = r_hit | w_any_edge;
    assign w_res_idx  = r_hit ? r_widx  : w_first_idx;
    assign w_res_time = r_hit ? r_wtime : (w_any_edge ? r_t : '0);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_t     <= '0;
            r_prev  <= '0;
            r_seen  <= '0;
            r_hit   <= 1'b0;
            r_widx  <= '0;
            r_wtime <= '0;
        end else begin
            // prev is never cleared at a boundary, so a straddling pulse gives no new edge.
            r_prev <= input_spikes;
            if (w_last) begin
                r_t     <= '0;
                r_seen  <= '0;
                r_hit   <= 1'b0;
                r_widx  <= '0;
                r_wtime <= '0;
            end else begin
                r_t    <= r_t + TW'(1);
                r_seen <= w_seen_next;
                if (!r_hit && w_any_edge) begin
                    r_hit   <= 1'b1;
                    r_widx  <= w_first_idx;
                    r_wtime <= r_t;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_o_hit    <= 1'b0;
            r_o_idx    <= '0;
            r_o_time   <= '0;
            r_o_count  <= '0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            if (r_valid && !res.out_ready) begin
                // Held result is not consumed yet: drop the new one.
                r_overflow <= 1'b1;
            end else begin
                r_valid   <= 1'b1;
                r_o_hit   <= w_res_hit;
                r_o_idx   <= w_res_idx;
                r_o_time  <= w_res_time;
                r_o_count <= w_count;
            end
        end else if (r_valid && res.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign res.out_valid = r_valid;
    assign res.out_hit   = r_o_hit;
    assign res.out_index = r_o_idx;
    assign res.out_time  = r_o_time;
    assign res.out_count = r_o_count;
    assign overflow      = r_overflow;

`ifdef PULSE_CHECK_EN
    localparam int PCW = $clog2(PULSE_WIDTH + 1);

    logic [PCW-1:0] r_run [NUM_INPUTS];
    logic           r_pulse_err;

    // r_run[i] counts consecutive high cycles already seen, saturating at PULSE_WIDTH;
    // one more high cycle beyond that is a pulse-length violation.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) r_run[i] <= '0;
            r_pulse_err <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (!input_spikes[i]) begin
                    r_run[i] <= '0;
                end else if (r_run[i] == PCW'(PULSE_WIDTH)) begin
                    r_pulse_err <= 1'b1;
                end else begin
                    r_run[i] <= r_run[i] + PCW'(1);
                end
            end
        end
    end

    assign pulse_err = r_pulse_err;
`endif
endmodule

// File: tb/tb_wta_spike_decoder.sv
// -----------------------------------------------------------------------------
// tb_wta_spike_decoder
// Self-checking bench for wta_spike_decoder: table of per-gamma-window spike
// scenarios with expected results pushed to a scoreboard queue, plus hand
// sequences for backpressure/overflow and mid-window reset.
// -----------------------------------------------------------------------------
module tb_wta_spike_decoder;
    localparam int GCW = 16;
    localparam int NI  = 128;
    localparam int PW  = 8;

    logic          aclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] spikes = '0;
    logic          gamma_start;
    logic          overflow;
`ifdef PULSE_CHECK_EN
    logic          pulse_err;
`endif

    wta_spike_decoder_if #(.GAMMA_CYCLE_WIDTH(GCW), .NUM_INPUTS(NI)) res ();

    wta_spike_decoder #(
        .GAMMA_CYCLE_WIDTH(GCW),
        .PULSE_WIDTH(PW),
        .NUM_INPUTS(NI)
    ) dut (
        .aclk(aclk),
        .rst_n(rst_n),
        .input_spikes(spikes),
        .gamma_start(gamma_start),
        .overflow(overflow),
`ifdef PULSE_CHECK_EN
        .pulse_err(pulse_err),
`endif
        .res(res)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int l0, t0, h0;
        int l1, t1, h1;
        int l2, t2, h2;
        int hit, idx, tm, cnt;
    } vec_t;

    typedef struct {
        int hit, idx, tm, cnt, due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tb_cyc;
    bit   mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit lvl(input int ts, input int h, input int t);
        return (t >= ts) && (t < ts + h);
    endfunction

    task automatic run_window(input vec_t v, input bit push);
        logic [NI-1:0] s;
        for (int t = 0; t < GCW; t++) begin
            s = '0;
            if (v.l0 >= 0 && lvl(v.t0, v.h0, t)) s[v.l0] = 1'b1;
            if (v.l1 >= 0 && lvl(v.t1, v.h1, t)) s[v.l1] = 1'b1;
            if (v.l2 >= 0 && lvl(v.t2, v.h2, t)) s[v.l2] = 1'b1;
            spikes = s;
            tick();
        end
        spikes = '0;
        if (push) q.push_back('{v.hit, v.idx, v.tm, v.cnt, tb_cyc});
    endtask

    task automatic check_out(input string tag, input int v, input int h, input int i,
                             input int tm, input int c, input int ov);
        check({tag, ".valid"},    32'(res.out_valid), v);
        check({tag, ".hit"},      32'(res.out_hit),   h);
        check({tag, ".index"},    32'(res.out_index), i);
        check({tag, ".time"},     32'(res.out_time),  tm);
        check({tag, ".count"},    32'(res.out_count), c);
        check({tag, ".overflow"}, 32'(overflow),      ov);
    endtask

    always @(posedge aclk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    always @(negedge aclk) begin
        exp_t e;
        if (rst_n) begin
            check("gamma_start", 32'(gamma_start), 32'((tb_cyc % GCW) == 0));
            if (mon_en && res.out_valid && res.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_result: out_valid=1 with index %0d, no result expected (t=%0t)",
                             res.out_index, $time);
                end else begin
                    n_cmp--;
                    e = q.pop_front();
                    check("sb.hit",     32'(res.out_hit),   e.hit);
                    check("sb.index",   32'(res.out_index), e.idx);
                    check("sb.time",    32'(res.out_time),  e.tm);
                    check("sb.count",   32'(res.out_count), e.cnt);
                    check("sb.latency", tb_cyc,             e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t silent;
        logic [NI-1:0] s;

        tbl[0] = '{37, 5, 8,  -1, 0, 0,  -1, 0, 0,  1, 37, 5, 1};   // single spike
        tbl[1] = '{90, 3, 4,  12, 3, 4,   0, 9, 2,  1, 12, 3, 3};   // tie + later edge
        tbl[2] = '{-1, 0, 0,  -1, 0, 0,  -1, 0, 0,  0, 0, 0, 0};    // silent
        tbl[3] = '{7, 15, 1,  -1, 0, 0,  -1, 0, 0,  1, 7, 15, 1};   // edge on last tick
        tbl[4] = '{7, -1, 4,  -1, 0, 0,  -1, 0, 0,  0, 0, 0, 0};    // straddle: no new edge
        tbl[5] = '{127, 0, 2,  5, 1, 1,  -1, 0, 0,  1, 127, 0, 2};  // top index at t=0
        tbl[6] = '{20, 2, 2,  20, 6, 1,  50, 10, 1, 1, 20, 2, 2};   // re-fire counts once
        tbl[7] = '{127, 14, 2, 0, 14, 2, 64, 15, 1, 1, 0, 14, 3};   // late tie, low index
        tbl[8] = '{1, 2, 9,   -1, 0, 0,  -1, 0, 0,  1, 1, 2, 1};    // over-long pulse
        silent = tbl[2];

        res.out_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        check("reset.gamma_start", 32'(gamma_start), 1);
`ifdef PULSE_CHECK_EN
        check("reset.pulse_err", 32'(pulse_err), 0);
`endif
        @(posedge aclk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_window(tbl[i], 1'b1);
`ifdef PULSE_CHECK_EN
        check("pulse_err_8cyc", 32'(pulse_err), 0);
`endif
        run_window(tbl[8], 1'b1);
`ifdef PULSE_CHECK_EN
        check("pulse_err_9cyc", 32'(pulse_err), 1);
`endif

        // Backpressure: A loads and is held, B is dropped, C loads on the accept edge.
        for (int t = 0; t < GCW; t++) begin
            s = '0;
            if (t == 4) s[10] = 1'b1;
            spikes = s;
            if (t == 1) begin
                res.out_ready = 1'b0;
                mon_en = 1'b0;
            end
            tick();
        end
        for (int t = 0; t < GCW; t++) begin
            s = '0;
            if (t == 6) s[11] = 1'b1;
            spikes = s;
            if (t == 1) begin
                @(negedge aclk);
                check_out("bp.held_A", 1, 1, 10, 4, 1, 0);
            end
            tick();
        end
        for (int t = 0; t < GCW; t++) begin
            s = '0;
            if (t == 8) s[12] = 1'b1;
            spikes = s;
            if (t == 0 || t == 9) begin
                @(negedge aclk);
                check_out("bp.kept_A", 1, 1, 10, 4, 1, 1);
            end
            if (t == 15) res.out_ready = 1'b1;
            tick();
        end
        spikes = '0;
        @(negedge aclk);
        check_out("bp.load_C", 1, 1, 12, 8, 1, 1);
        tick();
        @(negedge aclk);
        check("bp.valid_cleared", 32'(res.out_valid), 0);
        mon_en = 1'b1;
        tick();

        // Mid-window reset: line 3 fires at t=2, reset at t=8.
        for (int t = 2; t < 8; t++) begin
            s = '0;
            if (t == 2 || t == 3) s[3] = 1'b1;
            spikes = s;
            tick();
        end
        spikes = '0;
        rst_n = 1'b0;
        @(negedge aclk);
        check_out("midreset", 0, 0, 0, 0, 0, 0);
        check("midreset.gamma_start", 32'(gamma_start), 1);
`ifdef PULSE_CHECK_EN
        check("midreset.pulse_err", 32'(pulse_err), 0);
`endif
        @(posedge aclk);
        @(posedge aclk);
        #1;
        rst_n = 1'b1;
        run_window(silent, 1'b1);

        @(negedge aclk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
